square_seq: RTL and testbench

//  Sequential integer squarer; the inverse of the odd-number-subtraction square-root unit.

---
 rtl/square_seq.sv | 52 +++++
 tb/tb_square_seq.sv | 115 +++++++++++
 2 files changed

// File: rtl/square_seq.sv
// square_seq: sequential squarer, sums the first n odd numbers one term per clock
module square_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [WIDTH-1:0]   n,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] sq
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_nx;
  logic [2*WIDTH-1:0] sum;
  logic [WIDTH:0]     odd;
  logic [WIDTH-1:0]   cnt;
  logic               fin;
  assign fin  = (state == ACC) && (cnt == '0);
  assign busy = state != IDLE;
  // state register, aborts to IDLE on reset
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;
  // next state: go only counts in IDLE, ACC runs until the count drains, DONE lasts one cycle
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (go ? ACC : IDLE) :
               (state == ACC)  ? (fin ? DONE : ACC) : IDLE;
  end
  // accumulator datapath; sq and done only change on the final edge of a run
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sum  <= '0;
      odd  <= '0;
      cnt  <= '0;
      sq   <= '0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (state == IDLE && go) begin
        cnt <= n;
        sum <= '0;
        odd <= (WIDTH+1)'(1);
      end else if (state == ACC && !fin) begin
        sum <= sum + (2*WIDTH)'(odd);
        odd <= odd + (WIDTH+1)'(2);
        cnt <= cnt - WIDTH'(1);
      end
      if (fin) sq <= sum;
    end
endmodule

// File: tb/tb_square_seq.sv
// tb_square_seq: directed checks of the sequential squarer with round-trip square root
module tb_square_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [7:0]  n = '0;
  logic        busy, done;
  logic [15:0] sq;
  int          checks = 0;
  int          errors = 0;
  int          cyc;

  square_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .go(go), .n(n), .busy(busy), .done(done), .sq(sq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    int o = 1;
    while (v >= o) begin
      v -= o;
      o += 2;
      r++;
    end
    return r;
  endfunction

  task automatic run(input int nv, input int exp, input bit rt);
    go = 1'b1;
    n = 8'(nv);
    @(negedge clk);
    go = 1'b0;
    n = ~n;
    chk("busy_start", {31'b0, busy}, 1);
    cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, nv + 1);
    chk("sq", {16'b0, sq}, exp);
    chk("busy_done", {31'b0, busy}, 1);
    if (rt) chk("roundtrip", isqrt(int'(sq)), nv);
    @(negedge clk);
    chk("done_pulse", {31'b0, done}, 0);
    chk("busy_end", {31'b0, busy}, 0);
    chk("sq_hold", {16'b0, sq}, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_sq", {16'b0, sq}, 0);
    reset = 1'b0;
    @(negedge clk);
    run(0, 0, 1'b0);
    run(5, 25, 1'b0);
    run(255, 65025, 1'b0);
    go = 1'b1;
    n = 8'd7;
    @(negedge clk);
    cyc = 0;
    while (!done && cyc < 50) begin
      go = (cyc == 1);
      n = (cyc == 1) ? 8'd3 : 8'hAA;
      @(negedge clk);
      cyc++;
    end
    chk("busy_go_latency", cyc, 8);
    chk("busy_go_sq", {16'b0, sq}, 49);
    go = 1'b1;
    n = 8'd3;
    @(negedge clk);
    go = 1'b0;
    chk("done_go_busy", {31'b0, busy}, 0);
    chk("done_go_done", {31'b0, done}, 0);
    chk("done_go_sq", {16'b0, sq}, 49);
    @(negedge clk);
    chk("done_go_not_queued", {31'b0, busy}, 0);
    run(3, 9, 1'b0);
    go = 1'b1;
    n = 8'd100;
    @(negedge clk);
    go = 1'b0;
    repeat (39) @(negedge clk);
    chk("abort_busy_before", {31'b0, busy}, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_sq", {16'b0, sq}, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    repeat (70) begin
      @(negedge clk);
      if (done || busy) cyc++;
    end
    chk("abort_no_done", cyc, 0);
    for (int i = 0; i < 256; i++) run(i, i * i, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
